// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_responder                                             |
// | Purpose  : fixed-latency, little-endian 8-byte data-memory responder      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy
);

  localparam int unsigned c_aw       = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [63:0] c_max_addr = 64'(DEPTH_BYTES - 8);
  localparam logic [3:0]  c_lat_init = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic            r_write;
  logic            r_err;
  logic [c_aw-1:0] r_idx;
  logic [63:0]     r_wdata;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [63:0]     r_rsp_rdata;
  logic            r_rsp_err;
  logic            r_busy;
  logic [7:0]      r_mem [0:DEPTH_BYTES-1];

  logic            w_accept;
  logic            w_commit;
  logic            w_consume;
  logic [63:0]     w_rd_word;

  assign w_accept  = r_req_ready && i_req_valid;
  assign w_commit  = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_consume = r_rsp_valid && i_rsp_ready;

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Every latency, including 1, passes through WAIT so the response always
  // appears exactly LATENCY edges after acceptance.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_next = ST_WAIT;
      ST_WAIT: if (w_commit)  w_next = ST_RESP;
      ST_RESP: if (w_consume) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 64'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 64'd0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= i_req_write;
        r_err   <= (i_req_addr > c_max_addr);
        r_idx   <= i_req_addr[c_aw-1:0];
        r_wdata <= i_req_wdata;
        r_cnt   <= c_lat_init;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      r_req_ready <= (w_next == ST_IDLE);
      r_rsp_valid <= (w_next == ST_RESP);
      r_busy      <= (w_next != ST_IDLE);

      if (w_commit) begin
        r_rsp_err   <= r_err;
        r_rsp_rdata <= (r_write || r_err) ? 64'd0 : w_rd_word;
      end else if (w_consume) begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= 64'd0;
      end
    end
  end

  // Byte index wraps within c_aw bits; only reachable for errored accesses,
  // whose data is discarded.
  always_comb begin
    w_rd_word = 64'd0;
    for (int i = 0; i < 8; i++) begin
      w_rd_word[8*i +: 8] = r_mem[r_idx + c_aw'(i)];
    end
  end

  // Storage has no reset; a reset forces IDLE so a pending write never commits.
  always_ff @(posedge clk) begin
    if (w_commit && r_write && !r_err) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[r_idx + c_aw'(i)] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_mem_responder                                          |
// | Purpose  : self-checking bench, four responders at latencies 2,3,1,15     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;

  localparam int N     = 4;
  localparam int DEPTH = 1024;
  localparam int LATS [N] = '{2, 3, 1, 15};
  localparam int TMO   = 40;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [N];
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_write [N];
  logic [63:0] req_addr  [N];
  logic [63:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [63:0] rsp_rdata [N];
  logic        rsp_err   [N];
  logic        busy      [N];

  exp_t        sb [$];
  logic [7:0]  ref_mem [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < N; k++) begin : g_dut
      data_mem_responder #(
        .DEPTH_BYTES(DEPTH),
        .LATENCY    (LATS[k])
      ) u_dut (
        .clk        (clk),
        .reset      (rst[k]),
        .i_req_valid(req_valid[k]),
        .o_req_ready(req_ready[k]),
        .i_req_write(req_write[k]),
        .i_req_addr (req_addr[k]),
        .i_req_wdata(req_wdata[k]),
        .o_rsp_valid(rsp_valid[k]),
        .i_rsp_ready(rsp_ready[k]),
        .o_rsp_rdata(rsp_rdata[k]),
        .o_rsp_err  (rsp_err[k]),
        .o_busy     (busy[k])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Returns at the negedge following the acceptance edge.
  task automatic wait_accept(input int k);
    int n;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: instance %0d never ready", k);
    end
    @(negedge clk);
  endtask

  task automatic do_req(input int k, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rdata,
                        input logic exp_err, input bit chk_busy);
    exp_t e;
    int   lat;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = LATS[k];
    sb.push_back(e);
    rsp_ready[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_valid[k] = 1'b1;
    if (chk_busy) check("idle_busy", 64'(busy[k]), 64'd0);
    wait_accept(k);
    req_valid[k] = 1'b0;
    lat = 0;
    while (rsp_valid[k] !== 1'b1 && lat < TMO) begin
      if (chk_busy) check("wait_busy", 64'(busy[k]), 64'd1);
      @(negedge clk);
      lat++;
    end
    if (chk_busy) check("resp_busy", 64'(busy[k]), 64'd1);
    e = sb.pop_front();
    check("rsp_rdata", rsp_rdata[k], e.rdata);
    check("rsp_err", 64'(rsp_err[k]), 64'(e.err));
    check("latency", 64'(lat), 64'(e.lat));
    @(negedge clk);
    if (chk_busy) begin
      check("ready_after", 64'(req_ready[k]), 64'd1);
      check("busy_after", 64'(busy[k]), 64'd0);
    end
  endtask

  function automatic logic [63:0] model_rd(input int a);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = ref_mem[a + b];
    return v;
  endfunction

  task automatic model_wr(input int a, input logic [63:0] w);
    for (int b = 0; b < 8; b++) ref_mem[a + b] = w[8*b +: 8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vt [13];
    logic [63:0] w;
    logic [63:0] exp;
    int          a;
    int          b;
    int          lat;

    vt[0]  = '{1'b1, 64'h18,               64'h0,                 64'h0,                 1'b0};
    vt[1]  = '{1'b1, 64'h10,               64'h1122334455667788,  64'h0,                 1'b0};
    vt[2]  = '{1'b0, 64'h10,               64'h0,                 64'h1122334455667788,  1'b0};
    vt[3]  = '{1'b0, 64'h13,               64'h0,                 64'h0000001122334455,  1'b0};
    vt[4]  = '{1'b0, 64'h11,               64'h0,                 64'h0011223344556677,  1'b0};
    vt[5]  = '{1'b1, 64'h3F8,              64'h0123456789ABCDEF,  64'h0,                 1'b0};
    vt[6]  = '{1'b0, 64'h3F8,              64'h0,                 64'h0123456789ABCDEF,  1'b0};
    vt[7]  = '{1'b0, 64'h3F9,              64'h0,                 64'h0,                 1'b1};
    vt[8]  = '{1'b1, 64'hFFFFFFFFFFFFFFF8, 64'hDEADBEEFDEADBEEF,  64'h0,                 1'b1};
    vt[9]  = '{1'b0, 64'h3F8,              64'h0,                 64'h0123456789ABCDEF,  1'b0};
    vt[10] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0,                 64'h0,                 1'b1};
    vt[11] = '{1'b1, 64'h400,              64'h1,                 64'h0,                 1'b1};
    vt[12] = '{1'b0, 64'h0000000100000010, 64'h0,                 64'h0,                 1'b1};

    for (int k = 0; k < N; k++) begin
      rst[k]       = 1'b1;
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = 64'd0;
      req_wdata[k] = 64'd0;
      rsp_ready[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("reset_req_ready", 64'(req_ready[k]), 64'd1);
      check("reset_rsp_valid", 64'(rsp_valid[k]), 64'd0);
      check("reset_rdata", rsp_rdata[k], 64'd0);
      check("reset_err", 64'(rsp_err[k]), 64'd0);
      check("reset_busy", 64'(busy[k]), 64'd0);
      rst[k] = 1'b0;
    end
    @(negedge clk);

    // Directed vectors: basic access, endianness, range boundaries.
    for (int i = 0; i < 13; i++) begin
      do_req(0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err, 1'b0);
    end

    // Fill all storage so later reads are fully defined.
    for (int ad = 0; ad < DEPTH; ad += 8) begin
      w = {32'(ad) ^ 32'hA5A55A5A, 32'(ad) + 32'h01020304};
      model_wr(ad, w);
      do_req(0, 1'b1, 64'(ad), w, 64'd0, 1'b0, 1'b0);
    end

    // Back-to-back write/read pairs at unaligned addresses.
    for (int p = 0; p < 8; p++) begin
      a = int'($urandom_range(0, DEPTH - 9)) | 1;
      b = a + int'($urandom_range(0, 6)) - 3;
      if (b < 0) b = 0;
      if (b > DEPTH - 8) b = DEPTH - 8;
      w = {$urandom, $urandom};
      model_wr(a, w);
      do_req(0, 1'b1, 64'(a), w, 64'd0, 1'b0, 1'b1);
      do_req(0, 1'b0, 64'(b), 64'd0, model_rd(b), 1'b0, 1'b1);
    end

    // Back-pressure: response held, new request ignored, nothing queued.
    exp = model_rd(32'h101);
    rsp_ready[0] = 1'b0;
    req_write[0] = 1'b0;
    req_addr[0]  = 64'h101;
    req_valid[0] = 1'b1;
    wait_accept(0);
    req_addr[0]  = 64'h200;
    lat = 0;
    while (rsp_valid[0] !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 64'(lat), 64'(LATS[0]));
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", 64'(rsp_valid[0]), 64'd1);
      check("bp_rdata", rsp_rdata[0], exp);
      check("bp_req_ready", 64'(req_ready[0]), 64'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_valid_drop", 64'(rsp_valid[0]), 64'd0);
    check("bp_ready_back", 64'(req_ready[0]), 64'd1);
    @(negedge clk);
    check("bp_no_queue", 64'(rsp_valid[0]), 64'd0);
    check("bp_idle_busy", 64'(busy[0]), 64'd0);

    // Asynchronous reset during an in-flight write (latency 3).
    do_req(1, 1'b1, 64'h20, 64'h5555666677778888, 64'd0, 1'b0, 1'b1);
    req_write[1] = 1'b1;
    req_addr[1]  = 64'h20;
    req_wdata[1] = 64'hAA;
    req_valid[1] = 1'b1;
    wait_accept(1);
    req_valid[1] = 1'b0;
    @(negedge clk);
    #2 rst[1] = 1'b1;
    #1;
    check("arst_req_ready", 64'(req_ready[1]), 64'd1);
    check("arst_rsp_valid", 64'(rsp_valid[1]), 64'd0);
    check("arst_busy", 64'(busy[1]), 64'd0);
    check("arst_rdata", rsp_rdata[1], 64'd0);
    check("arst_err", 64'(rsp_err[1]), 64'd0);
    repeat (3) @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    do_req(1, 1'b0, 64'h20, 64'd0, 64'h5555666677778888, 1'b0, 1'b1);

    // Latency extremes.
    for (int k = 2; k < N; k++) begin
      do_req(k, 1'b1, 64'h41, 64'h0F1E2D3C4B5A6978, 64'd0, 1'b0, 1'b1);
      do_req(k, 1'b0, 64'h41, 64'd0, 64'h0F1E2D3C4B5A6978, 1'b0, 1'b1);
      do_req(k, 1'b1, 64'h3F9, 64'h1, 64'd0, 1'b1, 1'b1);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
